hazard_scoreboard: RTL

Parametrised hazard detector for the pipelined core, sitting beside the IF/ID and ID/EX registers. It tracks, per architectural register, how many cycles remain until an in-flight result can be forwarded. It stalls issue from ID on read-after-write hazards (load-use and multi-cycle results) and on a busy non-pipelined long-latency unit. It also keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_lat_counter.sv | 37 +++
 rtl/hazard_scoreboard.sv | 99 +++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and sizing helpers for the hazard scoreboard.
package hazard_pkg;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    // Counter width able to hold the larger latency; never narrower than one bit.
    function automatic int unsigned calc_cw(int unsigned load_lat, int unsigned long_lat);
        int unsigned m;
        m = (load_lat > long_lat) ? load_lat : long_lat;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction fields in, pipeline control and status out.
interface hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned STALL_CNT_W = 16
);
    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]            id_src_rd;
    logic [REG_ADDR_W-1:0]         id_dst_addr;
    logic                          id_reg_write;
    logic [1:0]                    id_class;
    logic                          flush;
    logic                          stall;
    logic                          pc_write_en;
    logic                          if_id_write_en;
    logic                          id_ex_bubble;
    logic [NUM_REGS-1:0]           busy_vec;
    logic [STALL_CNT_W-1:0]        stall_count;

    modport master (
        output id_valid, id_src_addr, id_src_rd, id_dst_addr, id_reg_write, id_class, flush,
        input  stall, pc_write_en, if_id_write_en, id_ex_bubble, busy_vec, stall_count
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_rd, id_dst_addr, id_reg_write, id_class, flush,
        output stall, pc_write_en, if_id_write_en, id_ex_bubble, busy_vec, stall_count
    );

endinterface

// File: rtl/hazard_lat_counter.sv
// Latency down-counter: loads a remaining-cycle count, then counts down to zero.
module hazard_lat_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] value_o,
    output logic          nonzero_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // A fresh load wins over the decrement (youngest writer wins).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register RAW scoreboard plus long-unit occupancy tracking and a stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned LONG_LAT    = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;
    localparam int unsigned CW       = calc_cw(LOAD_LAT, LONG_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOAD_LAT);
    localparam logic [CW-1:0] LONG_VAL = CW'(LONG_LAT);

    // Index NUM_REGS is the long unit; the rest are architectural registers.
    logic [CW-1:0]          cnt_val [NUM_REGS+1];
    logic [NUM_REGS:0]      cnt_nz;
    logic [NUM_REGS:0]      cnt_load;
    logic [CW-1:0]          issue_val;
    logic                   raw_hit, long_hit, stall, issue;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    // RAW check against pre-update counts, so a source equal to its own destination is safe.
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_src_rd[i] &&
                (cnt_val[bus.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]] != '0)) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign long_hit = (bus.id_class == CLS_LONG) & cnt_nz[NUM_REGS];
    assign stall    = bus.id_valid & ~bus.flush & (raw_hit | long_hit);
    assign issue    = bus.id_valid & ~bus.flush & ~stall;

    // Wait time of the issuing result; ALU and the reserved class forward immediately.
    always_comb begin
        case (bus.id_class)
            CLS_LOAD: issue_val = LOAD_VAL;
            CLS_LONG: issue_val = LONG_VAL;
            default:  issue_val = '0;
        endcase
    end

    // Load strobes: the destination register, and the long unit on any long-class issue.
    always_comb begin
        cnt_load = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_load[r] = issue & bus.id_reg_write & (bus.id_dst_addr == REG_ADDR_W'(r));
        end
        cnt_load[NUM_REGS] = issue & (bus.id_class == CLS_LONG);
    end

    for (genvar r = 0; r <= NUM_REGS; r++) begin : g_cnt
        hazard_lat_counter #(
            .CW (CW)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load_i     (cnt_load[r]),
            .load_val_i ((r == NUM_REGS) ? LONG_VAL : issue_val),
            .value_o    (cnt_val[r]),
            .nonzero_o  (cnt_nz[r])
        );
    end

    // Saturating stall-cycle count.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // Performance counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall          = stall;
    assign bus.pc_write_en    = ~stall;
    assign bus.if_id_write_en = ~stall;
    assign bus.id_ex_bubble   = stall | bus.flush;
    assign bus.busy_vec       = cnt_nz[NUM_REGS-1:0];
    assign bus.stall_count    = stall_count_q;

endmodule
